// File: rtl/rx_word_aligner.sv
// Word aligner behind the RX bit-alignment core: finds the training word at any bit offset,
// confirms it over LOCK_CNT consecutive valid words, then emits word-aligned data.
module rx_word_aligner #(
    parameter int unsigned                 DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0]       TRAIN_PATTERN  = 8'hB4,
    parameter int unsigned                 LOCK_CNT       = 8,
    parameter int unsigned                 SEARCH_TIMEOUT = 256
) (
    input  logic                          SCLK,
    input  logic                          RESET,
    input  logic                          BIT_ALGN_DONE,
    input  logic                          WORD_ALGN_RSTRT,
    input  logic [DATA_WIDTH-1:0]         RX_DATA,
    input  logic                          RX_VALID,
    output logic [DATA_WIDTH-1:0]         WORD_DATA,
    output logic                          WORD_VALID,
    output logic                          WORD_ALGN_DONE,
    output logic                          WORD_ALGN_ERR,
    output logic [$clog2(DATA_WIDTH)-1:0] WORD_ALGN_OFFS
);

    localparam int unsigned OFFS_W  = $clog2(DATA_WIDTH);
    localparam int unsigned TMO_W   = $clog2(SEARCH_TIMEOUT + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);

    localparam logic [TMO_W-1:0]   TMO_LIMIT   = TMO_W'(SEARCH_TIMEOUT);
    localparam logic [MATCH_W-1:0] MATCH_LIMIT = MATCH_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_CONFIRM,
        ST_LOCKED,
        ST_ERR
    } state_t;

    state_t               state, state_nxt;
    logic [OFFS_W-1:0]    offset, offset_nxt;
    logic [MATCH_W-1:0]   match_cnt, match_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_nxt, tmo_inc;
    logic [DATA_WIDTH-1:0] prev;

    logic [2*DATA_WIDTH-1:0] window;
    logic [DATA_WIDTH-1:0]   cand [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]   hit_vec;
    logic                    hit;
    logic [OFFS_W-1:0]       hit_offs;
    logic                    emit;

    // Earlier word occupies the low half so cand(k) is the word starting k bits late.
    assign window = {RX_DATA, prev};

    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_cand
        assign cand[k]    = window[k +: DATA_WIDTH];
        assign hit_vec[k] = (cand[k] == TRAIN_PATTERN);
    end

    always_comb begin
        hit      = 1'b0;
        hit_offs = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (!hit && hit_vec[i]) begin
                hit      = 1'b1;
                hit_offs = OFFS_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        match_nxt  = match_cnt;
        tmo_nxt    = tmo_cnt;
        tmo_inc    = (tmo_cnt == TMO_LIMIT) ? tmo_cnt : tmo_cnt + 1'b1;

        if (WORD_ALGN_RSTRT || (state != ST_IDLE && !BIT_ALGN_DONE)) begin
            state_nxt  = ST_IDLE;
            offset_nxt = '0;
            match_nxt  = '0;
            tmo_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    offset_nxt = '0;
                    match_nxt  = '0;
                    tmo_nxt    = '0;
                    if (BIT_ALGN_DONE) state_nxt = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (RX_VALID) begin
                        tmo_nxt = tmo_inc;
                        if (tmo_inc == TMO_LIMIT) begin
                            state_nxt = ST_ERR;
                        end else if (hit) begin
                            offset_nxt = hit_offs;
                            match_nxt  = MATCH_W'(1);
                            state_nxt  = (LOCK_CNT == 1) ? ST_LOCKED : ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (RX_VALID) begin
                        tmo_nxt = tmo_inc;
                        if (tmo_inc == TMO_LIMIT) begin
                            state_nxt = ST_ERR;
                        end else if (cand[offset] == TRAIN_PATTERN) begin
                            match_nxt = match_cnt + 1'b1;
                            if (match_nxt == MATCH_LIMIT) state_nxt = ST_LOCKED;
                        end else begin
                            match_nxt = '0;
                            state_nxt = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED, ST_ERR: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Words are only forwarded while the lock survives this cycle, so a drop or restart
    // suppresses WORD_VALID on the same edge that DONE falls.
    assign emit = RX_VALID && (state == ST_LOCKED) && (state_nxt == ST_LOCKED);

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state          <= ST_IDLE;
            offset         <= '0;
            match_cnt      <= '0;
            tmo_cnt        <= '0;
            prev           <= '0;
            WORD_DATA      <= '0;
            WORD_VALID     <= 1'b0;
            WORD_ALGN_DONE <= 1'b0;
            WORD_ALGN_ERR  <= 1'b0;
        end else begin
            state          <= state_nxt;
            offset         <= offset_nxt;
            match_cnt      <= match_nxt;
            tmo_cnt        <= tmo_nxt;
            if (RX_VALID) prev <= RX_DATA;
            WORD_VALID     <= emit;
            if (emit) WORD_DATA <= cand[offset];
            WORD_ALGN_DONE <= (state_nxt == ST_LOCKED);
            WORD_ALGN_ERR  <= (state_nxt == ST_ERR);
        end
    end

    assign WORD_ALGN_OFFS = offset;

endmodule

// File: tb/tb_rx_word_aligner.sv
// Directed scenarios plus a randomized run for rx_word_aligner, every cycle compared against
// a word-level reference model of the alignment rules.
module tb_rx_word_aligner;

    localparam int unsigned W    = 8;
    localparam logic [7:0]  PAT  = 8'hB4;
    localparam int          LOCK = 8;
    localparam int          TMO  = 256;

    logic       SCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BIT_ALGN_DONE = 1'b0;
    logic       WORD_ALGN_RSTRT = 1'b0;
    logic [7:0] RX_DATA = '0;
    logic       RX_VALID = 1'b0;
    logic [7:0] WORD_DATA;
    logic       WORD_VALID;
    logic       WORD_ALGN_DONE;
    logic       WORD_ALGN_ERR;
    logic [2:0] WORD_ALGN_OFFS;

    rx_word_aligner #(
        .DATA_WIDTH    (W),
        .TRAIN_PATTERN (PAT),
        .LOCK_CNT      (LOCK),
        .SEARCH_TIMEOUT(TMO)
    ) dut (
        .SCLK           (SCLK),
        .RESET          (RESET),
        .BIT_ALGN_DONE  (BIT_ALGN_DONE),
        .WORD_ALGN_RSTRT(WORD_ALGN_RSTRT),
        .RX_DATA        (RX_DATA),
        .RX_VALID       (RX_VALID),
        .WORD_DATA      (WORD_DATA),
        .WORD_VALID     (WORD_VALID),
        .WORD_ALGN_DONE (WORD_ALGN_DONE),
        .WORD_ALGN_ERR  (WORD_ALGN_ERR),
        .WORD_ALGN_OFFS (WORD_ALGN_OFFS)
    );

    always #5 SCLK = ~SCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: the stream is treated as words; a lock is a run of LOCK words whose
    // concatenation with the previous word contains the pattern at one fixed bit offset.
    logic [7:0] m_prev;
    bit         m_run, m_locked, m_err, m_wv;
    int         m_matches, m_words, m_offs;
    logic [7:0] m_wd;

    function automatic logic [7:0] pick(input logic [15:0] win, input int k);
        logic [15:0] t;
        t = win >> k;
        return t[7:0];
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] x, input int s);
        logic [15:0] t;
        t = {x, x} << s;
        return t[15:8];
    endfunction

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_locked = 0; m_err = 0; m_wv = 0;
        m_matches = 0; m_words = 0; m_offs = 0; m_wd = '0;
    endtask

    task automatic model_step(input bit rst, input bit bad, input bit rstrt,
                              input logic [7:0] d, input bit v);
        logic [15:0] win;
        bit          leave;
        int          found;
        if (rst) begin
            model_reset();
            return;
        end
        win   = {d, m_prev};
        leave = rstrt || (m_run && !bad);
        m_wv  = v && m_locked && !leave;
        if (m_wv) m_wd = pick(win, m_offs);
        if (leave) begin
            m_run = 0; m_locked = 0; m_err = 0;
            m_matches = 0; m_words = 0; m_offs = 0;
        end else if (!m_run) begin
            m_run = bad;
        end else if (v && !m_locked && !m_err) begin
            m_words++;
            if (m_words >= TMO) begin
                m_err = 1;
            end else if (m_matches == 0) begin
                found = -1;
                for (int k = W - 1; k >= 0; k--)
                    if (pick(win, k) == PAT) found = k;
                if (found >= 0) begin
                    m_offs    = found;
                    m_matches = 1;
                end
            end else if (pick(win, m_offs) == PAT) begin
                m_matches++;
            end else begin
                m_matches = 0;
            end
            if (!m_err && m_matches >= LOCK) m_locked = 1;
        end
        if (v) m_prev = d;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("done", 32'(WORD_ALGN_DONE), 32'(m_locked));
        check("err",  32'(WORD_ALGN_ERR),  32'(m_err));
        check("offs", 32'(WORD_ALGN_OFFS), 32'(m_offs));
        check("wvalid", 32'(WORD_VALID),   32'(m_wv));
        check("wdata", 32'(WORD_DATA),     32'(m_wd));
    endtask

    task automatic cycle(input bit rst, input bit bad, input bit rstrt,
                         input logic [7:0] d, input bit v);
        RESET = rst; BIT_ALGN_DONE = bad; WORD_ALGN_RSTRT = rstrt;
        RX_DATA = d; RX_VALID = v;
        @(posedge SCLK);
        model_step(rst, bad, rstrt, d, v);
        #1;
        compare_all();
    endtask

    // Feeds a constant word until DONE rises; returns the number of valid words used, or -1.
    task automatic run_until_done(input logic [7:0] d, input bit gaps, input int limit,
                                  output int nvalid);
        bit v;
        nvalid = 0;
        for (int i = 0; i < limit; i++) begin
            v = gaps ? (i % 2 == 1) : 1'b1;
            cycle(0, 1, 0, v ? d : 8'($urandom), v);
            if (v) nvalid++;
            if (WORD_ALGN_DONE) return;
        end
        nvalid = -1;
    endtask

    initial begin
        int n;
        int seg_len, skew;
        logic [7:0] w;
        bit bad, rstrt, v;

        model_reset();

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            cycle(1, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        check("rst_done",  32'(WORD_ALGN_DONE), 0);
        check("rst_err",   32'(WORD_ALGN_ERR), 0);
        check("rst_valid", 32'(WORD_VALID), 0);
        check("rst_data",  32'(WORD_DATA), 0);
        check("rst_offs",  32'(WORD_ALGN_OFFS), 0);

        // Skew 3: 8'hA5 repeated carries the pattern 3 bits late
        cycle(0, 1, 0, 8'hA5, 1);
        run_until_done(8'hA5, 0, 40, n);
        check("skew3_lock_words", 32'(n), 8);
        check("skew3_offs", 32'(WORD_ALGN_OFFS), 3);
        check("skew3_no_early_valid", 32'(WORD_VALID), 0);
        cycle(0, 1, 0, 8'hA5, 1);
        check("skew3_valid", 32'(WORD_VALID), 1);
        check("skew3_data", 32'(WORD_DATA), 32'h0B4);
        cycle(0, 1, 0, 8'hA5, 1);

        // Loss of bit alignment while locked, then relock
        cycle(0, 0, 0, 8'hA5, 1);
        check("loss_done", 32'(WORD_ALGN_DONE), 0);
        check("loss_valid", 32'(WORD_VALID), 0);
        check("loss_offs", 32'(WORD_ALGN_OFFS), 0);
        cycle(0, 1, 0, 8'hA5, 1);
        run_until_done(8'hA5, 0, 40, n);
        check("relock_words", 32'(n), 8);
        check("relock_offs", 32'(WORD_ALGN_OFFS), 3);

        // Confirm broken after 4 matches
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 1, 0, 8'hA5, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'hA5, 1);
        cycle(0, 1, 0, 8'h00, 1);
        check("break_no_done", 32'(WORD_ALGN_DONE), 0);
        run_until_done(8'hA5, 0, 40, n);
        check("break_relock_words", 32'(n), 9);
        check("break_offs", 32'(WORD_ALGN_OFFS), 3);

        // Timeout on a pattern-free stream, then restart
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 1, 0, 8'h00, 1);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            cycle(0, 1, 0, 8'h00, 1);
            if (WORD_ALGN_ERR) begin
                n = i;
                break;
            end
        end
        check("timeout_words", 32'(n), 256);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'hA5, 1);
        check("err_sticky", 32'(WORD_ALGN_ERR), 1);
        check("err_no_done", 32'(WORD_ALGN_DONE), 0);
        cycle(0, 1, 1, 8'hA5, 1);
        check("rstrt_err_clear", 32'(WORD_ALGN_ERR), 0);
        cycle(0, 1, 0, 8'hA5, 1);
        run_until_done(8'hA5, 0, 40, n);
        check("rstrt_lock_words", 32'(n), 8);

        // 50% RX_VALID duty
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 1, 0, 8'hA5, 1);
        run_until_done(8'hA5, 1, 80, n);
        check("gaps_lock_words", 32'(n), 8);
        for (int i = 0; i < 10; i++)
            cycle(0, 1, 0, (i % 2 == 1) ? 8'hA5 : 8'($urandom), 1'(i % 2));
        check("gaps_data_held", 32'(WORD_DATA), 32'h0B4);

        // Randomized segments of rotated training words with noise, gaps, drops, restarts
        cycle(1, 0, 0, 8'h00, 0);
        for (int s = 0; s < 60; s++) begin
            seg_len = int'($urandom_range(20, 80));
            skew    = int'($urandom_range(0, 7));
            w       = rol(PAT, skew);
            for (int i = 0; i < seg_len; i++) begin
                v     = ($urandom_range(0, 3) != 0);
                bad   = ($urandom_range(0, 150) != 0);
                rstrt = ($urandom_range(0, 200) == 0);
                cycle(0, bad, rstrt, ($urandom_range(0, 9) == 0) ? 8'($urandom) : w, v);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
